// File: rtl/sub_bytes_iter_if.sv
// sub_bytes_iter_if
// Groups the valid/ready handshake and data buses of the iterative SubBytes
// stage so the producer/consumer side and the block itself share one bundle.
//   in_valid   : upstream has a 132-bit word on data_in
//   in_ready   : block can take a word this cycle
//   data_in    : [131:128] header, [127:0] AES state (byte 0 in [127:120])
//   out_valid  : data_out/header_out hold a finished word
//   out_ready  : downstream takes the word this cycle
//   data_out   : header copy plus substituted state
//   header_out : same as data_out[131:128]
//   busy       : block is substituting columns
// Modports: master = the bench/surrounding logic, slave = the SubBytes block.
interface sub_bytes_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [131:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [131:0] data_out;
   logic [3:0]   header_out;
   logic         busy;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, header_out, busy
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, header_out, busy
   );
endinterface

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter
// Iterative AES SubBytes stage. Takes one 132-bit round word (4-bit header
// plus 128-bit state), substitutes one 32-bit column per clock through four
// shared S-boxes, then holds the result until the downstream stage takes it.
// A header of zero marks a bubble that is swallowed without output.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sub_bytes_iter_if.slave handshake/data bundle

// Forward AES S-box as a flat 256-byte table; entry 0 sits in the top byte.
module aes_sbox (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry b lives at bits [2047-8b -: 8]; {~b,3'b000} is its low bit.
   assign byte_out = SBOX_TABLE[{~byte_in, 3'b000} +: 8];
endmodule

module sub_bytes_iter (
   input  logic            clk,
   input  logic            rst,
   sub_bytes_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t       state;
   state_t       next_state;
   logic [1:0]   col;
   logic [1:0]   next_col;
   logic [3:0]   header;
   logic [3:0]   next_header;
   logic [127:0] work;
   logic [127:0] next_work;
   logic [31:0]  col_word;
   logic [31:0]  sub_word;
   logic         in_ready;
   logic         accept;
   logic         has_word;

   // Column col occupies [127-32*col -: 32]; {~col,5'b0} is its low bit.
   assign col_word = work[{~col, 5'b00000} +: 32];

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_in  (col_word[8*i +: 8]),
         .byte_out (sub_word[8*i +: 8])
      );
   end

   // The DONE handoff edge doubles as the next accept edge, so in_ready
   // follows out_ready combinationally there.
   assign in_ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
   assign accept   = bus.in_valid && in_ready;
   assign has_word = (bus.data_in[131:128] != 4'd0);

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state == DONE);
   assign bus.busy       = (state == SUB);
   assign bus.data_out   = {header, work};
   assign bus.header_out = header;

   // Next-state logic: load a non-bubble word on accept, substitute one
   // column per cycle in SUB, and leave DONE once downstream takes the word.
   always_comb begin
      next_state  = state;
      next_col    = col;
      next_header = header;
      next_work   = work;
      case (state)
         IDLE: begin
            if (accept && has_word) begin
               next_header = bus.data_in[131:128];
               next_work   = bus.data_in[127:0];
               next_col    = 2'd0;
               next_state  = SUB;
            end
         end
         SUB: begin
            next_work[{~col, 5'b00000} +: 32] = sub_word;
            next_col = col + 2'd1;
            if (col == 2'd3) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (accept && has_word) begin
                  next_header = bus.data_in[131:128];
                  next_work   = bus.data_in[127:0];
                  next_col    = 2'd0;
                  next_state  = SUB;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset clears everything so no partial word survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         col    <= 2'd0;
         header <= 4'd0;
         work   <= 128'd0;
      end else begin
         state  <= next_state;
         col    <= next_col;
         header <= next_header;
         work   <= next_work;
      end
   end
endmodule
